// File: rtl/a2d_round_robin_sched_if.sv
// SPI master handshake between the A2D scheduler and the shared SPI engine.
// The scheduler issues strobes and frames; the SPI side answers with done/resp.
interface a2d_round_robin_sched_if;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;

    modport master (output snd, output cmd, input done, input resp);
    modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/a2d_round_robin_sched.sv
// Round-robin A2D conversion scheduler: battery, current, brake, torque.
// Each slot runs a command frame then a read frame and stores the 12-bit result.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for slot_tick
// CMD      | snd strobe with the channel command frame
// WAIT_CMD | waiting for done on the command frame (watchdog armed)
// GAP      | one deselect cycle between frames
// READ     | snd strobe with the read frame
// WAIT_RD  | waiting for done on the read frame, capture resp (watchdog armed)
// STORE    | write held result, pulse cnv_cmplt, advance slot pointer
module a2d_round_robin_sched #(
    parameter bit FAST_SIM = 1'b0,
    parameter int TIMEOUT  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    a2d_round_robin_sched_if.master  spi,
    output logic [11:0]              batt,
    output logic [11:0]              curr,
    output logic [11:0]              brake,
    output logic [11:0]              torque,
    output logic                     cnv_cmplt,
    output logic [1:0]               chnl_upd,
    output logic                     timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WAIT_CMD,
        GAP,
        READ,
        WAIT_RD,
        STORE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [13:0]       slot_tmr;
    logic              slot_tick;
    logic [1:0]        ptr;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_expire;
    logic [11:0]       hold;
    logic [15:0]       cmd_q;
    logic [11:0]       result [4];

    function automatic logic [2:0] chan_of(input logic [1:0] slot);
        case (slot)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    assign slot_tick = FAST_SIM ? (&slot_tmr[9:0]) : (&slot_tmr);

    assign spi.snd = (state == CMD) || (state == READ);
    assign spi.cmd = cmd_q;

    assign batt   = result[0];
    assign curr   = result[1];
    assign brake  = result[2];
    assign torque = result[3];

    // A done landing on the final watchdog cycle is honoured ahead of the abort.
    always_comb begin
        state_nxt = state;
        wd_expire = 1'b0;
        case (state)
            IDLE:     if (slot_tick) state_nxt = CMD;
            CMD:      state_nxt = WAIT_CMD;
            WAIT_CMD: begin
                if (spi.done) begin
                    state_nxt = GAP;
                end else if (wd_cnt == '0) begin
                    state_nxt = IDLE;
                    wd_expire = 1'b1;
                end
            end
            GAP:      state_nxt = READ;
            READ:     state_nxt = WAIT_RD;
            WAIT_RD:  begin
                if (spi.done) begin
                    state_nxt = STORE;
                end else if (wd_cnt == '0) begin
                    state_nxt = IDLE;
                    wd_expire = 1'b1;
                end
            end
            STORE:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot_tmr    <= '0;
            ptr         <= '0;
            wd_cnt      <= '0;
            hold        <= '0;
            cmd_q       <= '0;
            cnv_cmplt   <= 1'b0;
            chnl_upd    <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < 4; i++) result[i] <= '0;
        end else begin
            state     <= state_nxt;
            slot_tmr  <= slot_tmr + 14'd1;
            cnv_cmplt <= 1'b0;

            if (state == IDLE && slot_tick) cmd_q <= {2'b00, chan_of(ptr), 11'h000};
            if (state == GAP)               cmd_q <= 16'h0000;

            // Down-counter reloads as each wait state is entered.
            if (state == CMD || state == READ) begin
                wd_cnt <= WD_W'(TIMEOUT - 1);
            end else if ((state == WAIT_CMD || state == WAIT_RD) && wd_cnt != '0) begin
                wd_cnt <= wd_cnt - WD_W'(1);
            end

            if (state == WAIT_RD && spi.done) hold <= spi.resp[11:0];

            if (state == STORE) begin
                result[ptr] <= hold;
                cnv_cmplt   <= 1'b1;
                chnl_upd    <= ptr;
                ptr         <= ptr + 2'd1;
            end

            if (wd_expire) begin
                timeout_err <= 1'b1;
                ptr         <= ptr + 2'd1;
            end
        end
    end

endmodule
